tank_level_model: RTL and testbench
===================================

// Module: tank_level_model
// PURPOSE
// - Synthesisable water-tank plant model: integrates valve inflow and consumer outflow into a level register.
// - Drives the three float-sensor lines H, M and L that the level/error decoder consumes, closing the irrigation control loop on-chip.
// - Used for FPGA demos without real sensors, and to inject sensor faults that exercise the decoder's Err path.
// PARAMETERS
// - LEVEL_W     8    width of level register
// - LEVEL_MAX   200  full-tank level; saturation ceiling
// - TH_L        40   level >= TH_L asserts L
// - TH_M        100  level >= TH_M asserts M
// - TH_H        160  level >= TH_H asserts H (TH_L < TH_M < TH_H <= LEVEL_MAX)
// - FILL_RATE   3    units added per tick while Ve=1
// - DRAIN_RATE  1    units removed per tick while Dr=1
// - TICK_DIV    1000 clock cycles per simulation tick (>=1)
// PORTS
// - Clk       in   1        system clock
// - Rst_n     in   1        synchronous reset, active-low
// - Ve        in   1        inlet valve open (from decoder)
// - Dr        in   1        consumer draw active (irrigation pump)
// - Ld        in   1        load Ld_val into level (test/preset)
// - Ld_val    in   LEVEL_W  preset value; clamped to LEVEL_MAX
// - Flt_sel   in   2        fault inject: 0 none, 1 M stuck-1, 2 L stuck-0, 3 H stuck-1
// - H, M, L   out  1 each   sensor lines (registered)
// - Level     out  LEVEL_W  current level
// - Ovf       out  1        sticky: inflow attempted while level==LEVEL_MAX
// - Dry       out  1        sticky: draw attempted while level==0
// - St        out  2        0 IDLE, 1 FILLING, 2 DRAINING, 3 BALANCED
// BEHAVIOUR
// - Clock and reset: single clock Clk; reset synchronous, active-low on Rst_n.
// - Reset values: Level=0, tick counter=0, H=M=L=0, Ovf=Dry=0, St=IDLE.
// - Tick: counter counts 0..TICK_DIV-1; tick pulses 1 cycle when the counter wraps.
//   - With TICK_DIV=1, tick fires every cycle.
// - Level update on the tick cycle only: next = Level + (Ve?FILL_RATE:0) - (Dr?DRAIN_RATE:0).
//   - Computed signed at LEVEL_W+2 bits, then clamped to [0, LEVEL_MAX]; never wraps.
// - Ld has priority over the tick update: Level <= min(Ld_val, LEVEL_MAX) in that cycle.
//   - Ld does not reset the tick counter; the sticky flags are not touched by Ld.
// - Ovf sets on a tick with Ve=1 and Level==LEVEL_MAX (pre-update). Cleared only by reset.
// - Dry sets on a tick with Dr=1 and Level==0 (pre-update). Cleared only by reset.
// - Sensors: raw H/M/L come from threshold compares on the updated Level and are registered.
//   - They therefore lag Level by 1 cycle.
//   - Fault override is applied after the compare, inside the same register.
//   - Flt_sel change takes effect on the next cycle.
// - St FSM, evaluated every cycle from the inputs (not gated by tick); St is a registered output.
//   - Ve=0, Dr=0 -> IDLE.
//   - Ve=1, Dr=0 -> FILLING.
//   - Ve=0, Dr=1 -> DRAINING.
//   - Ve=1, Dr=1 -> BALANCED.
//   - Each transition is direct and takes 1 cycle.
// - Reset asserted mid-operation: all state returns to reset values on that edge; no partial update.
// STRUCTURE
// - Shared package tank_pkg:
//   - St encoding constants (ST_IDLE..ST_BALANCED).
//   - Flt_sel encoding constants (FLT_NONE, FLT_M1, FLT_L0, FLT_H1).
// - Sub-module tick_gen: parameter TICK_DIV; ports Clk, Rst_n, tick.
// - All else (level integrator, threshold/fault register, flags, FSM) lives in the top module.
// TESTING (TICK_DIV=1 unless stated, defaults otherwise)
// - Reset: Rst_n=0 for 2 cycles with Ve=1 -> Level=0, H=M=L=0, Ovf=Dry=0, St=0.
// - Fill sweep: Ve=1, Dr=0 from 0.
//   - Level steps 3/cycle.
//   - L rises the cycle after Level>=40 (Level=42); M after 102; H after 162.
//   - Level saturates at 200; next tick sets Ovf=1.
// - Balance/drain: Ld=1 with Ld_val=250 -> Level=200.
//   - Then Ve=1, Dr=1 -> +2/tick clamped at 200, St=3.
//   - Then Dr only -> -1/tick, St=2.
//   - Then Ld_val=0 with Dr=1 -> Dry=1 on the following tick.
// - Fault inject: Level=20, Flt_sel=1 -> next cycle {H,M,L}=010 (decoder Err pattern).
//   - Flt_sel=0 -> next cycle {H,M,L}=000.
// - Tick divider: TICK_DIV=4, Ve=1 -> Level increments by 3 exactly every 4th cycle.
//   - Ld mid-count does not shift tick phase.
// - Reset mid-fill: at Level=120, assert Rst_n=0 one cycle -> Level=0 and {H,M,L}=000 next edge, Ovf stays 0.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared encodings for the water-tank plant model: FSM state values and
// fault-injection selector codes, plus a helper mapping flow inputs to a state.
package tank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FILLING  = 2'd1,
        ST_DRAINING = 2'd2,
        ST_BALANCED = 2'd3
    } st_t;

    localparam logic [1:0] FLT_NONE = 2'd0;
    localparam logic [1:0] FLT_M1   = 2'd1;
    localparam logic [1:0] FLT_L0   = 2'd2;
    localparam logic [1:0] FLT_H1   = 2'd3;

    function automatic st_t st_from_flow(input logic ve, input logic dr);
        st_t s;
        case ({ve, dr})
            2'b10:   s = ST_FILLING;
            2'b01:   s = ST_DRAINING;
            2'b11:   s = ST_BALANCED;
            default: s = ST_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tank_level_model_tick_gen.sv
// Simulation-tick generator: counts 0..TICK_DIV-1 and pulses tick for the
// single cycle in which the counter wraps. With TICK_DIV=1 tick is always high.
module tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic Clk,
    input  logic Rst_n,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running divider counter, wrapping at TICK_DIV-1
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/tank_level_model.sv
// Water-tank plant model: integrates valve inflow and consumer outflow into a
// saturating level register, drives registered H/M/L float-sensor lines with
// optional fault injection, keeps sticky overflow/dry flags and reports the
// current flow state.
module tank_level_model
    import tank_pkg::*;
#(
    parameter int LEVEL_W    = 8,
    parameter int LEVEL_MAX  = 200,
    parameter int TH_L       = 40,
    parameter int TH_M       = 100,
    parameter int TH_H       = 160,
    parameter int FILL_RATE  = 3,
    parameter int DRAIN_RATE = 1,
    parameter int TICK_DIV   = 1000
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Ve,
    input  logic               Dr,
    input  logic               Ld,
    input  logic [LEVEL_W-1:0] Ld_val,
    input  logic [1:0]         Flt_sel,
    output logic               H,
    output logic               M,
    output logic               L,
    output logic [LEVEL_W-1:0] Level,
    output logic               Ovf,
    output logic               Dry,
    output logic [1:0]         St
);

    localparam int SUM_W = LEVEL_W + 2;

    localparam logic [LEVEL_W-1:0]      MAX_V  = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0]      TH_L_V = LEVEL_W'(TH_L);
    localparam logic [LEVEL_W-1:0]      TH_M_V = LEVEL_W'(TH_M);
    localparam logic [LEVEL_W-1:0]      TH_H_V = LEVEL_W'(TH_H);
    localparam logic signed [SUM_W-1:0] MAX_S  = SUM_W'(LEVEL_MAX);
    localparam logic signed [SUM_W-1:0] FILL_S = SUM_W'(FILL_RATE);
    localparam logic signed [SUM_W-1:0] DRN_S  = SUM_W'(DRAIN_RATE);

    logic                      tick;
    logic signed [SUM_W-1:0]   sum_s;
    logic [LEVEL_W-1:0]        level_tick;
    logic [LEVEL_W-1:0]        level_load;
    logic                      h_d, m_d, l_d;
    st_t                       state_q, state_d;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .tick (tick)
    );

    // Signed net-flow sum with headroom, clamped into [0, LEVEL_MAX]
    always_comb begin
        sum_s = signed'({2'b00, Level});
        if (Ve) begin
            sum_s = sum_s + FILL_S;
        end
        if (Dr) begin
            sum_s = sum_s - DRN_S;
        end
        if (sum_s < 0) begin
            level_tick = '0;
        end else if (sum_s > MAX_S) begin
            level_tick = MAX_V;
        end else begin
            level_tick = sum_s[LEVEL_W-1:0];
        end
        level_load = (Ld_val > MAX_V) ? MAX_V : Ld_val;
    end

    // Level register: preset load wins over the tick update
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Level <= '0;
        end else if (Ld) begin
            Level <= level_load;
        end else if (tick) begin
            Level <= level_tick;
        end
    end

    // Sticky overflow/dry flags, judged on the pre-update level at each tick
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Ovf <= 1'b0;
            Dry <= 1'b0;
        end else if (tick) begin
            if (Ve && (Level == MAX_V)) begin
                Ovf <= 1'b1;
            end
            if (Dr && (Level == '0)) begin
                Dry <= 1'b1;
            end
        end
    end

    // Threshold compares on the current level, then fault override
    always_comb begin
        h_d = (Level >= TH_H_V);
        m_d = (Level >= TH_M_V);
        l_d = (Level >= TH_L_V);
        case (Flt_sel)
            FLT_M1:  m_d = 1'b1;
            FLT_L0:  l_d = 1'b0;
            FLT_H1:  h_d = 1'b1;
            default: ;
        endcase
    end

    // Sensor line register, one cycle behind the level
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            H <= 1'b0;
            M <= 1'b0;
            L <= 1'b0;
        end else begin
            H <= h_d;
            M <= m_d;
            L <= l_d;
        end
    end

    // Flow-state register, updated every cycle regardless of tick
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next flow state follows the valve/draw inputs directly
    always_comb begin
        state_d = ST_IDLE;
        state_d = st_from_flow(Ve, Dr);
    end

    assign St = state_q;

endmodule

// File: tb/tb_tank_level_model.sv
// Directed testbench for tank_level_model: one DUT with TICK_DIV=1 for the
// functional scenarios and a second with TICK_DIV=4 for the divider.
module tb_tank_level_model;

    logic       clk;
    logic       rst_n, ve, dr, ld;
    logic [7:0] ld_val;
    logic [1:0] flt_sel;
    logic       h, m, l, ovf, dry;
    logic [7:0] level;
    logic [1:0] st;

    logic       rst_n_d4, ve_d4, dr_d4, ld_d4;
    logic [7:0] ld_val_d4;
    logic [1:0] flt_sel_d4;
    logic       h_d4, m_d4, l_d4, ovf_d4, dry_d4;
    logic [7:0] level_d4;
    logic [1:0] st_d4;

    int total;
    int bad;

    tank_level_model #(.TICK_DIV(1)) u_dut (
        .Clk(clk), .Rst_n(rst_n), .Ve(ve), .Dr(dr), .Ld(ld), .Ld_val(ld_val),
        .Flt_sel(flt_sel), .H(h), .M(m), .L(l), .Level(level), .Ovf(ovf),
        .Dry(dry), .St(st)
    );

    tank_level_model #(.TICK_DIV(4)) u_dut4 (
        .Clk(clk), .Rst_n(rst_n_d4), .Ve(ve_d4), .Dr(dr_d4), .Ld(ld_d4),
        .Ld_val(ld_val_d4), .Flt_sel(flt_sel_d4), .H(h_d4), .M(m_d4), .L(l_d4),
        .Level(level_d4), .Ovf(ovf_d4), .Dry(dry_d4), .St(st_d4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ve = 1'b1;
        step();
        step();
        total++; if (level !== 8'd0) begin bad++; $display("[TB] FAIL reset_level: got %0d want 0", level); end
        total++; if ({h, m, l} !== 3'b000) begin bad++; $display("[TB] FAIL reset_hml: got %b want 000", {h, m, l}); end
        total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %b want 0", ovf); end
        total++; if (dry !== 1'b0) begin bad++; $display("[TB] FAIL reset_dry: got %b want 0", dry); end
        total++; if (st !== 2'd0) begin bad++; $display("[TB] FAIL reset_st: got %0d want 0", st); end
    endtask

    task automatic test_fill_sweep();
        logic [7:0] exp_lv;
        logic [2:0] exp_hml;
        logic       exp_ovf;
        int         cur, prev;
        rst_n = 1'b1;
        ve = 1'b1;
        dr = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            step();
            cur  = (3 * n > 200) ? 200 : 3 * n;
            prev = (3 * (n - 1) > 200) ? 200 : 3 * (n - 1);
            exp_lv  = 8'(cur);
            exp_hml = {prev >= 160, prev >= 100, prev >= 40};
            exp_ovf = (n >= 68);
            total++; if (level !== exp_lv) begin bad++; $display("[TB] FAIL fill_level n=%0d: got %0d want %0d", n, level, exp_lv); end
            total++; if ({h, m, l} !== exp_hml) begin bad++; $display("[TB] FAIL fill_hml n=%0d: got %b want %b", n, {h, m, l}, exp_hml); end
            total++; if (ovf !== exp_ovf) begin bad++; $display("[TB] FAIL fill_ovf n=%0d: got %b want %b", n, ovf, exp_ovf); end
            if (n == 1) begin
                total++; if (st !== 2'd1) begin bad++; $display("[TB] FAIL fill_st: got %0d want 1", st); end
            end
        end
    endtask

    task automatic test_balance_drain();
        ve = 1'b0;
        dr = 1'b0;
        ld = 1'b1;
        ld_val = 8'd50;
        step();
        total++; if (level !== 8'd50) begin bad++; $display("[TB] FAIL load50_level: got %0d want 50", level); end
        total++; if (st !== 2'd0) begin bad++; $display("[TB] FAIL idle_st: got %0d want 0", st); end
        ld_val = 8'd250;
        step();
        total++; if (level !== 8'd200) begin bad++; $display("[TB] FAIL load_clamp_level: got %0d want 200", level); end
        ld = 1'b0;
        ve = 1'b1;
        dr = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++; if (level !== 8'd200) begin bad++; $display("[TB] FAIL balance_level i=%0d: got %0d want 200", i, level); end
            total++; if (st !== 2'd3) begin bad++; $display("[TB] FAIL balance_st i=%0d: got %0d want 3", i, st); end
        end
        ve = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++; if (level !== 8'(200 - i)) begin bad++; $display("[TB] FAIL drain_level i=%0d: got %0d want %0d", i, level, 200 - i); end
            total++; if (st !== 2'd2) begin bad++; $display("[TB] FAIL drain_st i=%0d: got %0d want 2", i, st); end
        end
        ld = 1'b1;
        ld_val = 8'd0;
        step();
        total++; if (level !== 8'd0) begin bad++; $display("[TB] FAIL load0_level: got %0d want 0", level); end
        total++; if (dry !== 1'b0) begin bad++; $display("[TB] FAIL load0_dry: got %b want 0", dry); end
        ld = 1'b0;
        step();
        total++; if (level !== 8'd0) begin bad++; $display("[TB] FAIL dry_level: got %0d want 0", level); end
        total++; if (dry !== 1'b1) begin bad++; $display("[TB] FAIL dry_flag: got %b want 1", dry); end
        total++; if (ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky: got %b want 1", ovf); end
    endtask

    task automatic test_fault_inject();
        ve = 1'b0;
        dr = 1'b0;
        flt_sel = 2'd0;
        ld = 1'b1;
        ld_val = 8'd20;
        step();
        total++; if (level !== 8'd20) begin bad++; $display("[TB] FAIL flt_level20: got %0d want 20", level); end
        ld = 1'b0;
        flt_sel = 2'd1;
        step();
        total++; if ({h, m, l} !== 3'b010) begin bad++; $display("[TB] FAIL flt_m1: got %b want 010", {h, m, l}); end
        flt_sel = 2'd0;
        step();
        total++; if ({h, m, l} !== 3'b000) begin bad++; $display("[TB] FAIL flt_none20: got %b want 000", {h, m, l}); end
        flt_sel = 2'd3;
        step();
        total++; if ({h, m, l} !== 3'b100) begin bad++; $display("[TB] FAIL flt_h1: got %b want 100", {h, m, l}); end
        flt_sel = 2'd0;
        ld = 1'b1;
        ld_val = 8'd120;
        step();
        total++; if ({h, m, l} !== 3'b000) begin bad++; $display("[TB] FAIL flt_lag: got %b want 000", {h, m, l}); end
        ld = 1'b0;
        step();
        total++; if ({h, m, l} !== 3'b011) begin bad++; $display("[TB] FAIL flt_none120: got %b want 011", {h, m, l}); end
        flt_sel = 2'd2;
        step();
        total++; if ({h, m, l} !== 3'b010) begin bad++; $display("[TB] FAIL flt_l0: got %b want 010", {h, m, l}); end
        flt_sel = 2'd0;
        step();
        total++; if ({h, m, l} !== 3'b011) begin bad++; $display("[TB] FAIL flt_clear: got %b want 011", {h, m, l}); end
    endtask

    task automatic test_reset_mid_fill();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ve = 1'b1;
        dr = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            step();
        end
        total++; if (level !== 8'd120) begin bad++; $display("[TB] FAIL midfill_level: got %0d want 120", level); end
        total++; if ({h, m, l} !== 3'b011) begin bad++; $display("[TB] FAIL midfill_hml: got %b want 011", {h, m, l}); end
        rst_n = 1'b0;
        step();
        total++; if (level !== 8'd0) begin bad++; $display("[TB] FAIL midrst_level: got %0d want 0", level); end
        total++; if ({h, m, l} !== 3'b000) begin bad++; $display("[TB] FAIL midrst_hml: got %b want 000", {h, m, l}); end
        total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ovf: got %b want 0", ovf); end
        total++; if (dry !== 1'b0) begin bad++; $display("[TB] FAIL midrst_dry: got %b want 0", dry); end
        total++; if (st !== 2'd0) begin bad++; $display("[TB] FAIL midrst_st: got %0d want 0", st); end
        rst_n = 1'b1;
        ve = 1'b0;
        step();
        total++; if (level !== 8'd0) begin bad++; $display("[TB] FAIL postrst_level: got %0d want 0", level); end
        total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL postrst_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_tick_divider();
        logic [7:0] exp_lv;
        rst_n_d4 = 1'b1;
        ve_d4 = 1'b1;
        for (int n = 1; n <= 13; n++) begin
            step();
            exp_lv = 8'(3 * (n / 4));
            total++; if (level_d4 !== exp_lv) begin bad++; $display("[TB] FAIL div_level n=%0d: got %0d want %0d", n, level_d4, exp_lv); end
        end
        ld_d4 = 1'b1;
        ld_val_d4 = 8'd50;
        step();
        total++; if (level_d4 !== 8'd50) begin bad++; $display("[TB] FAIL div_load: got %0d want 50", level_d4); end
        ld_d4 = 1'b0;
        for (int n = 15; n <= 20; n++) begin
            step();
            exp_lv = (n < 16) ? 8'd50 : ((n < 20) ? 8'd53 : 8'd56);
            total++; if (level_d4 !== exp_lv) begin bad++; $display("[TB] FAIL div_phase n=%0d: got %0d want %0d", n, level_d4, exp_lv); end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0; ve = 1'b0; dr = 1'b0; ld = 1'b0; ld_val = 8'd0; flt_sel = 2'd0;
        rst_n_d4 = 1'b0; ve_d4 = 1'b0; dr_d4 = 1'b0; ld_d4 = 1'b0; ld_val_d4 = 8'd0; flt_sel_d4 = 2'd0;
        step();
        test_reset();
        test_fill_sweep();
        test_balance_drain();
        test_fault_inject();
        test_reset_mid_fill();
        test_tick_divider();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
